// File: rtl/mac_stop_mult_pkg.sv
// Shared definitions for the matrix-multiply sequencer/multiplier slice:
// default dimensions, derived widths and the sequencer state type.
package mac_stop_mult_pkg;

  // Counter/address width for a matrix dimension; never narrower than one bit
  function automatic int addr_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  localparam int DEF_M = 4;
  localparam int DEF_K = 4;
  localparam int DEF_N = 4;
  localparam int DEF_W = 32;

  localparam int ROW_A_W = addr_w(DEF_M);
  localparam int COL_A_W = addr_w(DEF_K);
  localparam int ROW_B_W = addr_w(DEF_K);
  localparam int COL_B_W = addr_w(DEF_N);

  // Full-precision product, and the width a downstream accumulator needs
  // to sum K such products without overflow
  localparam int PRODUCT_W = 2 * DEF_W;
  localparam int RESULT_W  = 2 * DEF_W + $clog2(DEF_K);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    MULT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mac_stop_mult_addr_gen.sv
// Nested i/j/k counters for the matrix walk. k is innermost, then j, then i.
// The counters freeze once the final triple (M-1, N-1, K-1) is reached.
module mac_stop_mult_addr_gen
  import mac_stop_mult_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int K = DEF_K,
  parameter int N = DEF_N
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 advance_i,
  output logic [addr_w(M)-1:0] i_o,
  output logic [addr_w(K)-1:0] k_o,
  output logic [addr_w(N)-1:0] j_o,
  output logic                 last_o
);

  localparam int IW = addr_w(M);
  localparam int KW = addr_w(K);
  localparam int JW = addr_w(N);

  logic [IW-1:0] i_q, i_d;
  logic [KW-1:0] k_q, k_d;
  logic [JW-1:0] j_q, j_d;
  logic          k_wrap;
  logic          j_wrap;

  assign k_wrap = (k_q == KW'(K - 1));
  assign j_wrap = (j_q == JW'(N - 1));
  assign last_o = k_wrap && j_wrap && (i_q == IW'(M - 1));

  assign i_o = i_q;
  assign k_o = k_q;
  assign j_o = j_q;

  // Next-count logic: k rolls into j, j rolls into i; nothing moves past the last triple
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (advance_i && !last_o) begin
      if (k_wrap) begin
        k_d = '0;
        if (j_wrap) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  // Counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/mac_stop_mult.sv
// Sequencer and multiplier stage of a matrix-multiply MAC. Walks every (i,j,k)
// triple, reads A[i][k] and B[k][j] from external memories and registers their
// full-width product with a one-cycle valid pulse. do_mac low stalls the walk.
module mac_stop_mult
  import mac_stop_mult_pkg::*;
#(
  parameter int M                      = DEF_M,
  parameter int K                      = DEF_K,
  parameter int N                      = DEF_N,
  parameter int DATA_WIDTH_INIT_MATRIX = DEF_W
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  do_mac,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_a,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_b,
  output logic [addr_w(M)-1:0]                  row_addr_a,
  output logic [addr_w(K)-1:0]                  col_addr_a,
  output logic [addr_w(K)-1:0]                  row_addr_b,
  output logic [addr_w(N)-1:0]                  col_addr_b,
  output logic                                  matrix_a_re,
  output logic                                  matrix_b_re,
  output logic [2*DATA_WIDTH_INIT_MATRIX-1:0]   product_reg,
  output logic                                  mult_done_reg,
  output logic                                  mac_done,
  output logic [addr_w(M)-1:0]                  matrix_a_row_addr_counter_reg,
  output logic [addr_w(K)-1:0]                  matrix_a_col_addr_counter_reg,
  output logic [addr_w(K)-1:0]                  matrix_b_row_addr_counter_reg,
  output logic [addr_w(N)-1:0]                  matrix_b_col_addr_counter_reg
);

  localparam int PW = 2 * DATA_WIDTH_INIT_MATRIX;

  state_e                state_q, state_d;
  logic [PW-1:0]         product_q, product_d;
  logic                  mult_done_q, mult_done_d;
  logic                  read_en;
  logic                  advance;
  logic                  last_triple;
  logic [addr_w(M)-1:0]  i_cnt;
  logic [addr_w(K)-1:0]  k_cnt;
  logic [addr_w(N)-1:0]  j_cnt;

  mac_stop_mult_addr_gen #(
    .M (M),
    .K (K),
    .N (N)
  ) u_addr_gen (
    .clk_i     (clk),
    .reset_i   (resetn),
    .advance_i (advance),
    .i_o       (i_cnt),
    .k_o       (k_cnt),
    .j_o       (j_cnt),
    .last_o    (last_triple)
  );

  assign matrix_a_row_addr_counter_reg = i_cnt;
  assign matrix_a_col_addr_counter_reg = k_cnt;
  assign matrix_b_row_addr_counter_reg = k_cnt;
  assign matrix_b_col_addr_counter_reg = j_cnt;

  assign row_addr_a = i_cnt;
  assign col_addr_a = k_cnt;
  assign row_addr_b = k_cnt;
  assign col_addr_b = j_cnt;

  assign matrix_a_re   = read_en;
  assign matrix_b_re   = read_en;
  assign product_reg   = product_q;
  assign mult_done_reg = mult_done_q;
  assign mac_done      = (state_q == DONE);

  // Sequencer: operands returned during READ are sampled and multiplied at
  // READ's closing edge, so the product and its pulse are visible during MULT;
  // MULT then steps the counters. do_mac low freezes everything in place.
  always_comb begin
    state_d     = state_q;
    product_d   = product_q;
    mult_done_d = 1'b0;
    read_en     = 1'b0;
    advance     = 1'b0;
    case (state_q)
      IDLE: begin
        if (do_mac) begin
          state_d = READ;
        end
      end
      READ: begin
        if (do_mac) begin
          read_en     = 1'b1;
          product_d   = PW'(data_in_a) * PW'(data_in_b);
          mult_done_d = 1'b1;
          state_d     = MULT;
        end
      end
      MULT: begin
        if (do_mac) begin
          advance = 1'b1;
          state_d = last_triple ? DONE : READ;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, product and pulse registers with synchronous reset
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= IDLE;
      product_q   <= '0;
      mult_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      product_q   <= product_d;
      mult_done_q <= mult_done_d;
    end
  end

endmodule

// File: tb/tb_mac_stop_mult.sv
// Self-checking bench for mac_stop_mult: behavioural matrix memories, an
// independent walk model that queues expected products at read time, and
// per-scenario tasks that compare DUT outputs against that queue.
module tb_mac_stop_mult;

  logic        clk = 1'b0;
  logic        resetn;
  logic        do_mac;
  logic [31:0] data_in_a;
  logic [31:0] data_in_b;
  logic [1:0]  row_addr_a, col_addr_a, row_addr_b, col_addr_b;
  logic        matrix_a_re, matrix_b_re;
  logic [63:0] product_reg;
  logic        mult_done_reg;
  logic        mac_done;
  logic [1:0]  cnt_ai, cnt_ak, cnt_bk, cnt_bj;

  int checks = 0;
  int passes = 0;

  logic        forceOnes = 1'b0;
  logic [31:0] matA [4][4];
  logic [31:0] matB [4][4];
  logic [63:0] expQ [$];
  int          ei, ej, ek;

  mac_stop_mult dut (
    .clk                           (clk),
    .resetn                        (resetn),
    .do_mac                        (do_mac),
    .data_in_a                     (data_in_a),
    .data_in_b                     (data_in_b),
    .row_addr_a                    (row_addr_a),
    .col_addr_a                    (col_addr_a),
    .row_addr_b                    (row_addr_b),
    .col_addr_b                    (col_addr_b),
    .matrix_a_re                   (matrix_a_re),
    .matrix_b_re                   (matrix_b_re),
    .product_reg                   (product_reg),
    .mult_done_reg                 (mult_done_reg),
    .mac_done                      (mac_done),
    .matrix_a_row_addr_counter_reg (cnt_ai),
    .matrix_a_col_addr_counter_reg (cnt_ak),
    .matrix_b_row_addr_counter_reg (cnt_bk),
    .matrix_b_col_addr_counter_reg (cnt_bj)
  );

  always #5 clk = ~clk;

  // Combinational-read memories addressed by the DUT
  assign data_in_a = forceOnes ? 32'hFFFF_FFFF : matA[row_addr_a][col_addr_a];
  assign data_in_b = forceOnes ? 32'hFFFF_FFFF : matB[row_addr_b][col_addr_b];

  task automatic modelStep;
    if (ek == 3) begin
      ek = 0;
      if (ej == 3) begin
        ej = 0;
        ei++;
      end else begin
        ej++;
      end
    end else begin
      ek++;
    end
  endtask

  task automatic applyReset;
    @(negedge clk);
    resetn = 1'b1;
    do_mac = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
  endtask

  task automatic test_reset;
    applyReset();
    @(negedge clk);
    checks++;
    if (product_reg !== 64'd0) $display("[TB] FAIL reset_product: got %0h expected 0", product_reg);
    else passes++;
    checks++;
    if (mult_done_reg !== 1'b0 || mac_done !== 1'b0)
      $display("[TB] FAIL reset_flags: got done=%b mac_done=%b expected 0 0", mult_done_reg, mac_done);
    else passes++;
    checks++;
    if (matrix_a_re !== 1'b0 || matrix_b_re !== 1'b0)
      $display("[TB] FAIL reset_re: got %b%b expected 00", matrix_a_re, matrix_b_re);
    else passes++;
    checks++;
    if ({cnt_ai, cnt_ak, cnt_bk, cnt_bj} !== 8'd0 || {row_addr_a, col_addr_a, row_addr_b, col_addr_b} !== 8'd0)
      $display("[TB] FAIL reset_counters: got %h/%h expected 00/00",
               {cnt_ai, cnt_ak, cnt_bk, cnt_bj}, {row_addr_a, col_addr_a, row_addr_b, col_addr_b});
    else passes++;
  endtask

  task automatic test_walk_with_stall;
    int unsigned firstExp [4];
    int          pulses;
    int          cycles;
    logic [63:0] firstSum;
    logic [63:0] lastProd;
    logic [63:0] expVal;
    logic [7:0]  savedAddr;
    logic [63:0] savedProd;
    logic        prevRead;
    int          extraPulses;
    firstExp = '{6, 2, 15, 4};
    expQ.delete();
    ei = 0; ej = 0; ek = 0;
    pulses = 0; cycles = 0; firstSum = 0; lastProd = 0; prevRead = 1'b0;
    applyReset();
    do_mac = 1'b1;
    while (pulses < 64 && cycles < 600) begin
      @(negedge clk);
      cycles++;
      if (mult_done_reg) begin
        pulses++;
        checks++;
        if (!prevRead || expQ.size() == 0)
          $display("[TB] FAIL pulse_latency: pulse %0d got prevRead=%b queued=%0d expected 1 and >0",
                   pulses, prevRead, expQ.size());
        else begin
          expVal = expQ.pop_front();
          if (product_reg !== expVal)
            $display("[TB] FAIL product_%0d: got %0d expected %0d", pulses, product_reg, expVal);
          else passes++;
        end
        if (pulses <= 4) begin
          checks++;
          if (product_reg !== 64'(firstExp[pulses-1]))
            $display("[TB] FAIL first_product_%0d: got %0d expected %0d", pulses, product_reg, firstExp[pulses-1]);
          else passes++;
          firstSum += product_reg;
        end
        if (pulses == 4) begin
          checks++;
          if (firstSum !== 64'd27) $display("[TB] FAIL c00_sum: got %0d expected 27", firstSum);
          else passes++;
        end
        if (pulses == 6) begin
          checks++;
          if (product_reg !== 64'd14) $display("[TB] FAIL after_stall_product: got %0d expected 14", product_reg);
          else passes++;
        end
        lastProd = product_reg;
        if (pulses == 5) begin
          do_mac    = 1'b0;
          savedAddr = {row_addr_a, col_addr_a, row_addr_b, col_addr_b};
          savedProd = product_reg;
          repeat (3) begin
            @(negedge clk);
            cycles++;
            checks++;
            if (mult_done_reg !== 1'b0 || matrix_a_re !== 1'b0 || matrix_b_re !== 1'b0 ||
                {row_addr_a, col_addr_a, row_addr_b, col_addr_b} !== savedAddr || product_reg !== savedProd)
              $display("[TB] FAIL stall_frozen: got done=%b re=%b%b addr=%h prod=%0d expected 0 00 %h %0d",
                       mult_done_reg, matrix_a_re, matrix_b_re,
                       {row_addr_a, col_addr_a, row_addr_b, col_addr_b}, product_reg, savedAddr, savedProd);
            else passes++;
          end
          do_mac = 1'b1;
          prevRead = 1'b0;
          continue;
        end
      end
      if (matrix_a_re) begin
        checks++;
        if ({row_addr_a, col_addr_a, row_addr_b, col_addr_b, matrix_b_re} !== {2'(ei), 2'(ek), 2'(ek), 2'(ej), 1'b1})
          $display("[TB] FAIL read_addr: got %h expected %h",
                   {row_addr_a, col_addr_a, row_addr_b, col_addr_b, matrix_b_re},
                   {2'(ei), 2'(ek), 2'(ek), 2'(ej), 1'b1});
        else passes++;
        expQ.push_back(64'(matA[ei][ek]) * 64'(matB[ek][ej]));
        modelStep();
      end
      prevRead = matrix_a_re;
    end
    checks++;
    if (pulses != 64) $display("[TB] FAIL pulse_count: got %0d expected 64 (cycle budget)", pulses);
    else passes++;
    @(negedge clk);
    checks++;
    if (mac_done !== 1'b1) $display("[TB] FAIL mac_done_set: got %b expected 1", mac_done);
    else passes++;
    checks++;
    if (lastProd !== 64'd6 || product_reg !== 64'd6)
      $display("[TB] FAIL last_product: got %0d/%0d expected 6", lastProd, product_reg);
    else passes++;
    checks++;
    if ({cnt_ai, cnt_ak, cnt_bk, cnt_bj} !== 8'hFF || expQ.size() != 0)
      $display("[TB] FAIL final_counters: got %h queued=%0d expected ff 0", {cnt_ai, cnt_ak, cnt_bk, cnt_bj}, expQ.size());
    else passes++;
    extraPulses = 0;
    for (int c = 0; c < 6; c++) begin
      do_mac = (c != 1);
      @(negedge clk);
      if (mult_done_reg || matrix_a_re || !mac_done) extraPulses++;
    end
    checks++;
    if (extraPulses != 0) $display("[TB] FAIL done_hold: got %0d bad cycles expected 0", extraPulses);
    else passes++;
    do_mac = 1'b0;
  endtask

  task automatic test_all_ones;
    int cycles;
    applyReset();
    forceOnes = 1'b1;
    do_mac = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!mult_done_reg && cycles < 20);
    checks++;
    if (!mult_done_reg || product_reg !== 64'hFFFF_FFFE_0000_0001)
      $display("[TB] FAIL all_ones_product: got %h (pulse=%b) expected fffffffe00000001", product_reg, mult_done_reg);
    else passes++;
    forceOnes = 1'b0;
    do_mac = 1'b0;
  endtask

  task automatic test_mid_run_reset;
    int   cycles;
    logic found;
    applyReset();
    do_mac = 1'b1;
    cycles = 0;
    found = 1'b0;
    while (!found && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (matrix_a_re && row_addr_a == 2'd1 && col_addr_b == 2'd2 && col_addr_a == 2'd3) found = 1'b1;
    end
    checks++;
    if (!found) $display("[TB] FAIL reach_triple_123: got timeout expected triple (1,2,3)");
    else passes++;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({cnt_ai, cnt_ak, cnt_bk, cnt_bj} !== 8'd0 || product_reg !== 64'd0 || mac_done !== 1'b0 || mult_done_reg !== 1'b0)
      $display("[TB] FAIL mid_reset_clear: got cnt=%h prod=%0d mac_done=%b done=%b expected 00 0 0 0",
               {cnt_ai, cnt_ak, cnt_bk, cnt_bj}, product_reg, mac_done, mult_done_reg);
    else passes++;
    resetn = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!matrix_a_re && cycles < 20);
    checks++;
    if (!matrix_a_re || {row_addr_a, col_addr_a, row_addr_b, col_addr_b} !== 8'd0)
      $display("[TB] FAIL restart_addr: got re=%b addr=%h expected 1 00",
               matrix_a_re, {row_addr_a, col_addr_a, row_addr_b, col_addr_b});
    else passes++;
    @(negedge clk);
    checks++;
    if (mult_done_reg !== 1'b1 || product_reg !== 64'd6)
      $display("[TB] FAIL restart_product: got done=%b prod=%0d expected 1 6", mult_done_reg, product_reg);
    else passes++;
    do_mac = 1'b0;
  endtask

  initial begin
    matA = '{'{32'd6, 32'd2, 32'd5, 32'd2}, '{32'd6, 32'd2, 32'd6, 32'd1},
             '{32'd2, 32'd4, 32'd5, 32'd2}, '{32'd7, 32'd2, 32'd5, 32'd1}};
    matB = '{'{32'd1, 32'd1, 32'd4, 32'd4}, '{32'd1, 32'd7, 32'd2, 32'd1},
             '{32'd3, 32'd2, 32'd1, 32'd1}, '{32'd2, 32'd1, 32'd6, 32'd6}};
    resetn = 1'b1;
    do_mac = 1'b0;
    test_reset();
    test_walk_with_stall();
    test_all_ones();
    test_mid_run_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
